// File: rtl/edge_to_level_driver.sv
// Turns per-bit one-cycle change pulses back into held levels.
// mode 0 stretches each pulse to HOLD_CYCLES high cycles (retriggerable); mode 1 toggles the bit.
module edge_to_level_driver #(
    parameter int unsigned NUM_BITS    = 18,
    parameter int unsigned HOLD_CYCLES = 25000000,
    localparam int unsigned CNT_W      = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BITS-1:0] edge_in,
    input  logic                mode,
    input  logic                clear,
    output logic [NUM_BITS-1:0] level_out,
    output logic                busy
);

    typedef enum logic {ModeStretch = 1'b0, ModeToggle = 1'b1} mode_e;

    logic [CNT_W-1:0]    cnt_q [NUM_BITS];
    logic [CNT_W-1:0]    cnt_d [NUM_BITS];
    logic [NUM_BITS-1:0] level_q, level_d;
    mode_e               mode_q;
    logic                flush;

    // A mode change wipes every channel so no stale hold or toggle state survives the switch.
    assign flush = clear | (mode != mode_q);

    always_comb begin
        level_d = level_q;
        for (int i = 0; i < NUM_BITS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (flush) begin
            level_d = '0;
            for (int i = 0; i < NUM_BITS; i++) begin
                cnt_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < NUM_BITS; i++) begin
                if (mode_q == ModeStretch) begin
                    if (edge_in[i]) begin
                        cnt_d[i]   = CNT_W'(HOLD_CYCLES);
                        level_d[i] = 1'b1;
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i]   = cnt_q[i] - CNT_W'(1);
                        level_d[i] = (cnt_q[i] != CNT_W'(1));
                    end
                end else begin
                    cnt_d[i] = '0;
                    if (edge_in[i]) begin
                        level_d[i] = ~level_q[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            mode_q  <= mode_e'(mode);
            for (int i = 0; i < NUM_BITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            mode_q  <= mode_e'(mode);
            for (int i = 0; i < NUM_BITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level_out = level_q;
    assign busy      = |level_q;

endmodule

// File: tb/tb_edge_to_level_driver.sv
// Self-checking bench for edge_to_level_driver: directed scenarios plus randomized traffic,
// compared against a timestamp/parity reference model.
module tb_edge_to_level_driver;

    localparam int unsigned NUM  = 18;
    localparam int unsigned HOLD = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NUM-1:0]  edge_in = '0;
    logic            mode = 1'b0;
    logic            clear = 1'b0;
    logic [NUM-1:0]  level_out;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // Reference model: stretch channels remember the cycle their hold expires, toggle channels
    // remember their parity.
    longint cyc = 0;
    longint expire [NUM];
    bit     tog [NUM];
    bit     mode_m = 1'b0;

    edge_to_level_driver #(
        .NUM_BITS   (NUM),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .edge_in  (edge_in),
        .mode     (mode),
        .clear    (clear),
        .level_out(level_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM-1:0] exp_level();
        logic [NUM-1:0] e;
        for (int i = 0; i < NUM; i++) begin
            e[i] = mode_m ? tog[i] : (cyc < expire[i]);
        end
        return e;
    endfunction

    task automatic model_wipe();
        for (int i = 0; i < NUM; i++) begin
            expire[i] = 0;
            tog[i]    = 1'b0;
        end
    endtask

    // Drive inputs away from the edge, take one clock edge, update the model, settle.
    task automatic step(input logic [NUM-1:0] e, input logic m, input logic c, input logic r);
        @(negedge clk);
        edge_in = e;
        mode    = m;
        clear   = c;
        reset   = r;
        @(posedge clk);
        cyc++;
        if (r || c || (m != mode_m)) begin
            model_wipe();
        end else begin
            for (int i = 0; i < NUM; i++) begin
                if (e[i]) begin
                    if (!mode_m) expire[i] = cyc + HOLD;
                    else         tog[i]    = ~tog[i];
                end
            end
        end
        mode_m = m;
        #1;
    endtask

    task automatic test_reset();
        logic [NUM-1:0] want;
        step(18'h2A5A5, 1'b0, 1'b0, 1'b1);
        step(18'h3FFFF, 1'b0, 1'b0, 1'b1);
        want = '0;
        checks++;
        if (level_out !== want || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: level_out=%h busy=%b, want %h busy=0", level_out, busy, want);
        end
    endtask

    task automatic test_isolated();
        logic [NUM-1:0] want;
        int high = 0;
        step(18'h00001, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            want = exp_level();
            high += int'(level_out[0]);
            checks++;
            if (level_out !== want || busy !== (|want)) begin
                errors++;
                $display("FAIL isolated cyc=%0d: level_out=%h busy=%b, want %h", cyc, level_out,
                         busy, want);
            end
            step('0, 1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (high != HOLD) begin
            errors++;
            $display("FAIL isolated_len: high cycles=%0d, want %0d", high, HOLD);
        end
    endtask

    task automatic test_retrigger();
        logic [NUM-1:0] want;
        for (int k = 0; k < 11; k++) begin
            step((k == 0 || k == 4) ? 18'h00008 : 18'h0, 1'b0, 1'b0, 1'b0);
            want = exp_level();
            checks++;
            if (level_out !== want || busy !== (|want)) begin
                errors++;
                $display("FAIL retrigger k=%0d: level_out=%h busy=%b, want %h", k, level_out, busy,
                         want);
            end
        end
    endtask

    task automatic test_toggle();
        logic [NUM-1:0] want;
        step('0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step((k == 0 || k == 3 || k == 4) ? 18'h20000 : 18'h0, 1'b1, 1'b0, 1'b0);
            want = exp_level();
            checks++;
            if (level_out !== want || busy !== (|want)) begin
                errors++;
                $display("FAIL toggle k=%0d: level_out=%h busy=%b, want %h", k, level_out, busy,
                         want);
            end
        end
    endtask

    task automatic test_simul_clear();
        logic [NUM-1:0] want;
        step('0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step(k == 0 ? 18'h3FFFF : (k == 2 ? 18'h00020 : 18'h0), 1'b0, k == 2, 1'b0);
            want = exp_level();
            checks++;
            if (level_out !== want || busy !== (|want)) begin
                errors++;
                $display("FAIL simul_clear k=%0d: level_out=%h busy=%b, want %h", k, level_out,
                         busy, want);
            end
        end
    endtask

    task automatic test_mode_change();
        logic [NUM-1:0] want;
        step('0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step((k == 0 || k == 2 || k == 4) ? 18'h00001 : 18'h0, k >= 2, 1'b0, 1'b0);
            want = exp_level();
            checks++;
            if (level_out !== want || busy !== (|want)) begin
                errors++;
                $display("FAIL mode_change k=%0d: level_out=%h busy=%b, want %h", k, level_out,
                         busy, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NUM-1:0] want;
        step('0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step((k == 0 || k == 2) ? 18'h00004 : 18'h0, 1'b0, 1'b0, k == 2);
            want = exp_level();
            checks++;
            if (level_out !== want || busy !== (|want)) begin
                errors++;
                $display("FAIL reset_mid k=%0d: level_out=%h busy=%b, want %h", k, level_out,
                         busy, want);
            end
        end
    endtask

    task automatic test_random();
        logic [NUM-1:0] want;
        logic           m = mode;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 39) == 0) m = ~m;
            step(NUM'($urandom & $urandom & $urandom), m, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 99) == 0);
            want = exp_level();
            checks++;
            if (level_out !== want || busy !== (|want)) begin
                errors++;
                $display("FAIL random cyc=%0d: level_out=%h busy=%b, want %h", cyc, level_out,
                         busy, want);
            end
        end
    endtask

    initial begin
        model_wipe();
        test_reset();
        test_isolated();
        test_retrigger();
        test_toggle();
        test_simul_clear();
        test_mode_change();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
